// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, opcode field position and the
// load/store unit state machine encoding.
package cpu_pkg;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 27;
  localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t INST_LW  = 5'd0;
  localparam opcode_t INST_SW  = 5'd1;
  localparam opcode_t INST_ADD = 5'd3;
  localparam opcode_t INST_SUB = 5'd4;
  localparam opcode_t INST_AND = 5'd5;
  localparam opcode_t INST_OR  = 5'd6;
  localparam opcode_t INST_XOR = 5'd7;
  localparam opcode_t INST_SLL = 5'd8;
  localparam opcode_t INST_SRL = 5'd9;
  localparam opcode_t INST_SRA = 5'd10;
  localparam opcode_t INST_SLT = 5'd11;
  localparam opcode_t INST_NOT = 5'd12;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_DONE,
    LSU_ERR
  } lsu_state_e;

  function automatic logic is_mem_op(opcode_t op);
    return (op == INST_LW) || (op == INST_SW);
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/ack transfer on the data-memory port per
// LW/SW, stalls the pipeline through busy and returns load data to writeback.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] instr,
  input  logic [DWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              wb_en,
  output logic [DWIDTH-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_lw_q, is_lw_d;
  logic              mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wb_en_q, wb_en_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;

  opcode_t op;
  logic    legal;
  logic    unused_instr_bits;

  assign op                = instr[OPCODE_HI:OPCODE_LO];
  assign legal             = is_mem_op(op) && (addr[1:0] == 2'b00);
  assign unused_instr_bits = ^instr[OPCODE_LO-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_lw_d     = is_lw_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          if (legal) begin
            state_d     = LSU_REQ;
            cnt_d       = '0;
            is_lw_d     = (op == INST_LW);
            mem_we_d    = (op == INST_SW);
            mem_addr_d  = addr[AWIDTH-1:0];
            mem_wdata_d = wdata;
          end else begin
            state_d = LSU_ERR;
          end
        end
      end
      LSU_REQ: begin
        // An ack in the final allowed cycle still beats the timeout.
        if (mem_ack) begin
          if (is_lw_q) rdata_d = mem_rdata;
          state_d = LSU_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LSU_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      LSU_ERR:  state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d    = (state_d != LSU_IDLE);
    mem_req_d = (state_d == LSU_REQ);
    done_d    = (state_d == LSU_DONE);
    wb_en_d   = (state_d == LSU_DONE) && is_lw_d;
    err_d     = (state_d == LSU_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      is_lw_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_lw_q     <= is_lw_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wb_en_q     <= wb_en_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wb_en     = wb_en_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Transaction-level bench for load_store_unit: directed cases then random
// LW/SW/illegal traffic, with the bench acting as data memory.
module tb_load_store_unit;

  localparam int DWIDTH  = 32;
  localparam int AWIDTH  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DWIDTH-1:0] instr;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              busy;
  logic              done;
  logic              wb_en;
  logic [DWIDTH-1:0] rdata;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_ack;
  logic [DWIDTH-1:0] mem_rdata;

  int          n_compared;
  int          n_mismatched;
  logic [31:0] model_rdata;

  load_store_unit #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .instr    (instr),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .wb_en    (wb_en),
    .rdata    (rdata),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One whole transaction seen from the memory side. ack_at is the index of
  // the request cycle in which the bench acks; anything >= TIMEOUT means never.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] wd, input int ack_at,
                               input logic [31:0] load_val, input bit hold_start,
                               input bit late_ack);
    bit          legal;
    bit          acked;
    int          seen;
    int          exp_cycles;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    legal     = (op == 5'd0 || op == 5'd1) && (a[1:0] == 2'b00);
    acked     = legal && (ack_at >= 0) && (ack_at < TIMEOUT);
    exp_addr  = a;
    exp_wdata = wd;
    exp_cycles = !legal ? 0 : (acked ? ack_at + 1 : TIMEOUT);

    start = 1'b1;
    instr = {op, 27'($urandom)};
    addr  = a;
    wdata = wd;
    @(negedge clk);
    if (hold_start) begin
      addr  = ~a;
      wdata = ~wd;
    end else begin
      start = 1'b0;
    end

    seen = 0;
    while (mem_req === 1'b1 && seen < TIMEOUT + 4) begin
      checkOutput("req_busy", busy, 1'b1);
      checkOutput("req_we", mem_we, (op == 5'd1));
      checkOutput("req_addr", mem_addr, exp_addr);
      checkOutput("req_wdata", mem_wdata, exp_wdata);
      mem_ack   = (seen == ack_at);
      mem_rdata = (seen == ack_at) ? load_val : $urandom;
      seen++;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    checkOutput("req_cycles", seen, exp_cycles);

    start = 1'b0;
    if (acked && op == 5'd0) model_rdata = load_val;
    checkOutput("out_busy", busy, 1'b1);
    checkOutput("out_done", done, acked);
    checkOutput("out_wb_en", wb_en, acked && op == 5'd0);
    checkOutput("out_err", err, !acked);
    checkOutput("out_req", mem_req, 1'b0);
    checkOutput("out_rdata", rdata, model_rdata);

    if (late_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_done", done, 1'b0);
    checkOutput("idle_err", err, 1'b0);
    checkOutput("idle_req", mem_req, 1'b0);
    if (late_ack) begin
      @(negedge clk);
      mem_ack = 1'b0;
      checkOutput("late_done", done, 1'b0);
      checkOutput("late_wb_en", wb_en, 1'b0);
      checkOutput("late_rdata", rdata, model_rdata);
    end
  endtask

  initial begin
    logic [4:0]  r_op;
    logic [31:0] r_addr;
    int          r_ack;

    n_compared   = 0;
    n_mismatched = 0;
    model_rdata  = '0;
    rst_n        = 1'b0;
    start        = 1'b0;
    instr        = '0;
    addr         = '0;
    wdata        = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_wb_en", wb_en, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_req", mem_req, 1'b0);
    checkOutput("rst_we", mem_we, 1'b0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed transactions");
    applyStimulus(5'd0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(5'd1, 32'h204, 32'h12345678, 0, 32'hCAFEF00D, 1'b0, 1'b0);
    applyStimulus(5'd3, 32'h100, 32'h1, 0, 32'h11111111, 1'b0, 1'b0);
    applyStimulus(5'd0, 32'h102, 32'h1, 0, 32'h22222222, 1'b0, 1'b0);
    applyStimulus(5'd0, 32'h300, 32'h0, TIMEOUT + 5, 32'h33333333, 1'b0, 1'b1);
    applyStimulus(5'd0, 32'h304, 32'h0, TIMEOUT - 1, 32'h44444444, 1'b0, 1'b0);
    applyStimulus(5'd1, 32'h308, 32'hA5A5A5A5, 3, 32'h55555555, 1'b1, 1'b0);

    $display("[TB] reset mid-request");
    start = 1'b1;
    instr = {5'd0, 27'h0};
    addr  = 32'h400;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_rdata = '0;
    checkOutput("arst_req", mem_req, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_rdata", rdata, model_rdata);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(5'd0, 32'h500, 32'h0, 1, 32'h0BADF00D, 1'b0, 1'b0);

    $display("[TB] random transactions");
    for (int i = 0; i < 40; i++) begin
      r_op   = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(2, 31));
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      r_ack  = ($urandom_range(0, 4) == 0) ? TIMEOUT + 1 : $urandom_range(0, TIMEOUT - 1);
      applyStimulus(r_op, r_addr, $urandom, r_ack, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
